reg_heap_view: RTL and testbench
================================

# reg_heap_view

Parametrised, pipelined successor to the register-heap overlay. Renders `REG_COUNT` register rows, each `REG_WIDTH` bits, as a vertical stack centred on (`cx`, `cy`). Register values are sampled once per frame so a row never tears mid-frame. Any register whose value changed between frames is flagged for `HIGHLIGHT_FRAMES` frames. Sits between the CPU register file and the VGA pixel mixer, which ORs `hit` into the foreground and uses `highlight` to recolour it.

## Interface
Parameters:
- `REG_COUNT`, 8, number of rows rendered; register 0 is the top row.
- `REG_WIDTH`, 16, bits per register.
- `ROW_PITCH`, 60, vertical distance in pixels between row centres; must be even.
- `HIGHLIGHT_FRAMES`, 30, frames a changed row stays highlighted; 0 disables highlighting.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank.
- `x`, `y`  in  11 each  current pixel coordinate.
- `cx`, `cy`  in  11 each  centre of the stack.
- `registers`  in  `REG_COUNT*REG_WIDTH`  live register file; register i is at `[(REG_COUNT-i)*REG_WIDTH-1 -: REG_WIDTH]`, so register 0 is the MSB slice.
- `hit`  out  1  pixel is foreground of any row.
- `highlight`  out  1  pixel is foreground of a row whose highlight counter is non-zero.

## Operation
Frame snapshot:
- On a cycle with `frame_start`=1 and `rst`=0, `snap` is loaded from `registers` at that clock edge.
- All rendering uses `snap` only; it never uses live `registers`.
- `snap_valid` is set by the first such load.

Change detection, per row i:
- On each load with `snap_valid`=1: if the new value differs from `snap[i]`, load `cnt[i]` with `HIGHLIGHT_FRAMES`.
- Otherwise, if `cnt[i]`>0, decrement `cnt[i]` by 1.
- A change while `cnt[i]`>0 reloads the counter; it does not accumulate.
- A counter at 0 stays at 0.
- The first load after reset (`snap_valid`=0) never loads counters.
- Counter width is `$clog2(HIGHLIGHT_FRAMES+1)`, with a minimum of 1 bit.

Geometry:
- Row i is centred at `cx` horizontally and at `cy + (2i+1-REG_COUNT)*(ROW_PITCH/2)` vertically.
- Geometry arithmetic is 11-bit, modulo 2048. Wrapped rows render wherever they land; there is no clipping.
- For `REG_COUNT`=8 and `ROW_PITCH`=60, the row offsets are -210, -150, … , +210.

Rendering:
- Each row is one glyph renderer fed `x`, `y`, the row centre, index i and `snap[i]`. It produces `row_hit[i]`, combinationally.
- `hit` = OR of `row_hit`.
- `highlight` = OR of (`row_hit[i]` AND `cnt[i]`≠0).
- Overlapping rows (small `ROW_PITCH`) simply OR together.

Simultaneous events:
- `rst` together with `frame_start`: reset wins.
- `frame_start` on consecutive cycles: each pulse is a full load and decrement step.

## Timing
- Reset values: `hit`=0, `highlight`=0, `snap`=0, `snap_valid`=0, all `cnt`=0. The pipeline is cleared, so outputs are 0 for 2 cycles after `rst` deasserts.
- Pipeline latency is 2 cycles from (`x`, `y`) to outputs:
  - stage 1 registers the `row_hit` vector and the `cnt`≠0 vector;
  - stage 2 registers `hit` and `highlight`.
- The pixel mixer delays the sync signals by 2 to match.
- With `frame_start` at cycle t, `snap` is new from cycle t+1. Outputs reflect the new `snap` from cycle t+3.
- `cnt` updates at the same edge as `snap`.
- Throughput: one pixel per clock, no stalls, no handshake.

## Structure
- Sub-module `register_row_renderer`: glyph renderer for one row, with `x`, `y`, `cx`, `cy`, `index`, `value` and `hit`. Width generalised to `REG_WIDTH`. Instantiated in a generate loop over `REG_COUNT`.
- Shared package `vga_pkg`:
  - `COORD_W`=11;
  - glyph cell width and height constants used by the row renderer;
  - function `row_offset(i, count, pitch)`, which returns the signed 11-bit row offset.
- Counters and snapshot stay local to `reg_heap_view`.

## Test plan
- Reset: hold `rst` for 3 cycles with random `x`/`y` → `hit`=`highlight`=0 throughout and for 2 cycles after release.
- Snapshot and latency:
  - `registers` row 3 = 0xFFFF, `frame_start` at t, `cx`=320, `cy`=240 → row 3 centre is y=210;
  - drive a foreground pixel of row 3 at t+1 → `hit`=1 at t+3;
  - changing `registers` mid-frame without `frame_start` → output unchanged.
- First frame: first `frame_start` after reset with non-zero values → all `cnt`=0, `highlight` never 1.
- Highlight lifetime (`HIGHLIGHT_FRAMES`=3):
  - row 5 changes 0x0000→0x1234 at load k → `highlight` on row-5 pixels during frames k, k+1, k+2 and 0 from load k+3;
  - a second change at load k+1 → counter reloads, highlight lasts until load k+4.
- `rst` with `frame_start` in the same cycle → `snap` stays 0, `snap_valid`=0.
- Parametrisation: `REG_COUNT`=16, `REG_WIDTH`=32, `ROW_PITCH`=30 → row 0 centre at `cy`-225, row 15 at `cy`+225; hits appear only at those centres ± glyph height.

Source files
------------

// File: rtl/vga_pkg.sv
// +------------------------------------------------------------------+
// | vga_pkg : coordinate width, glyph cell geometry, row placement   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

    localparam int COORD_W = 11;
    localparam int CELL_W  = 8;   // power of two; last column is the inter-cell gap
    localparam int CELL_H  = 16;

    // Vertical offset of row i's centre from the stack centre, wrapped to COORD_W bits.
    function automatic logic signed [COORD_W-1:0] row_offset(input int i, input int count,
                                                            input int pitch);
        int off;
        off = (2 * i + 1 - count) * (pitch / 2);
        return COORD_W'(off);
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_row_renderer.sv
// +------------------------------------------------------------------+
// | register_row_renderer : one row glyph {index, gap, value} bits   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module register_row_renderer
    import vga_pkg::*;
#(
    parameter int REG_WIDTH = 16,
    parameter int IDX_W     = 3
) (
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    input  logic [COORD_W-1:0]   cx,
    input  logic [COORD_W-1:0]   cy,
    input  logic [IDX_W-1:0]     index,
    input  logic [REG_WIDTH-1:0] value,
    output logic                 hit
);

    localparam int N_CELLS = IDX_W + 1 + REG_WIDTH;
    localparam int TOTAL_W = N_CELLS * CELL_W;
    localparam int CELL_SH = $clog2(CELL_W);
    localparam logic [COORD_W-1:0] HALF_W = COORD_W'(TOTAL_W / 2);
    localparam logic [COORD_W-1:0] HALF_H = COORD_W'(CELL_H / 2);

    logic [N_CELLS-1:0] w_glyph;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [COORD_W-1:0] w_cell;
    logic [CELL_SH-1:0] w_col;
    logic               w_in_box;
    logic               w_bit;

    // Modular offsets from the top-left corner: wrapped rows still render.
    always_comb begin
        w_glyph  = {index, 1'b0, value};
        w_dx     = x - (cx - HALF_W);
        w_dy     = y - (cy - HALF_H);
        w_in_box = (w_dx < COORD_W'(TOTAL_W)) && (w_dy < COORD_W'(CELL_H));
        w_cell   = w_dx >> CELL_SH;
        w_col    = w_dx[CELL_SH-1:0];
        w_bit    = 1'b0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (w_cell == COORD_W'(k)) begin
                w_bit = w_glyph[N_CELLS-1-k];
            end
        end
        hit = w_in_box && (w_col != '1) && w_bit;
    end

endmodule

`default_nettype wire

// File: rtl/reg_heap_view.sv
// +------------------------------------------------------------------+
// | reg_heap_view : per-frame register snapshot overlay, 2-stage     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module reg_heap_view
    import vga_pkg::*;
#(
    parameter int REG_COUNT        = 8,
    parameter int REG_WIDTH        = 16,
    parameter int ROW_PITCH        = 60,
    parameter int HIGHLIGHT_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             x,
    input  logic [COORD_W-1:0]             y,
    input  logic [COORD_W-1:0]             cx,
    input  logic [COORD_W-1:0]             cy,
    input  logic [REG_COUNT*REG_WIDTH-1:0] registers,
    output logic                           hit,
    output logic                           highlight
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int CNT_W = (HIGHLIGHT_FRAMES > 0) ? $clog2(HIGHLIGHT_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] HF_VAL = CNT_W'(HIGHLIGHT_FRAMES);

    logic [REG_COUNT*REG_WIDTH-1:0] r_snap;
    logic                           r_snap_valid;
    logic [CNT_W-1:0]               r_cnt [REG_COUNT];
    logic [REG_COUNT-1:0]           w_row_hit;
    logic [REG_COUNT-1:0]           w_cnt_nz;
    logic [REG_COUNT-1:0]           r_row_hit;
    logic [REG_COUNT-1:0]           r_cnt_nz;

    // Snapshot and highlight counters advance together once per frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap       <= '0;
            r_snap_valid <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (frame_start) begin
            r_snap       <= registers;
            r_snap_valid <= 1'b1;
            if (r_snap_valid) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    if (registers[(REG_COUNT-i)*REG_WIDTH-1 -: REG_WIDTH] !=
                        r_snap[(REG_COUNT-i)*REG_WIDTH-1 -: REG_WIDTH]) begin
                        r_cnt[i] <= HF_VAL;
                    end else if (r_cnt[i] != '0) begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_rows
        localparam logic [COORD_W-1:0] OFF = row_offset(g, REG_COUNT, ROW_PITCH);
        logic [COORD_W-1:0] w_row_cy;

        assign w_row_cy    = cy + OFF;
        assign w_cnt_nz[g] = (r_cnt[g] != '0);

        register_row_renderer #(
            .REG_WIDTH (REG_WIDTH),
            .IDX_W     (IDX_W)
        ) u_row (
            .x     (x),
            .y     (y),
            .cx    (cx),
            .cy    (w_row_cy),
            .index (IDX_W'(g)),
            .value (r_snap[(REG_COUNT-g)*REG_WIDTH-1 -: REG_WIDTH]),
            .hit   (w_row_hit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_hit <= '0;
            r_cnt_nz  <= '0;
            hit       <= 1'b0;
            highlight <= 1'b0;
        end else begin
            r_row_hit <= w_row_hit;
            r_cnt_nz  <= w_cnt_nz;
            hit       <= |r_row_hit;
            highlight <= |(r_row_hit & r_cnt_nz);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_heap_view.sv
// +------------------------------------------------------------------+
// | tb_reg_heap_view : directed checks for reg_heap_view             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_reg_heap_view;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_start;
    logic         frame_start2;
    logic [10:0]  x, y, cx, cy;
    logic [127:0] registers;
    logic [511:0] registers2;
    logic         hit, highlight, hit2, highlight2;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    reg_heap_view #(
        .REG_COUNT(8), .REG_WIDTH(16), .ROW_PITCH(60), .HIGHLIGHT_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .x(x), .y(y), .cx(cx), .cy(cy),
        .registers(registers), .hit(hit), .highlight(highlight)
    );

    reg_heap_view #(
        .REG_COUNT(16), .REG_WIDTH(32), .ROW_PITCH(30), .HIGHLIGHT_FRAMES(30)
    ) dut2 (
        .clk(clk), .rst(rst), .frame_start(frame_start2), .x(x), .y(y), .cx(cx), .cy(cy),
        .registers(registers2), .hit(hit2), .highlight(highlight2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start = 1'b0; frame_start2 = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    task automatic pulse2();
        frame_start2 = 1'b1; step(); frame_start2 = 1'b0;
    endtask

    task automatic set_row(input int i, input logic [15:0] v);
        registers[(8-i)*16-1 -: 16] = v;
    endtask

    // Present a pixel and wait out the two-stage pipeline.
    task automatic render(input logic [10:0] px, input logic [10:0] py);
        x = px; y = py; step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; frame_start2 = 1'b0;
        registers = '1; cx = 11'd320; cy = 11'd240;
        for (int i = 0; i < 3; i++) begin
            x = 11'($urandom_range(0, 2047)); y = 11'($urandom_range(0, 2047));
            step();
            n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit[%0d]: got %b want 0", i, hit); end
            n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL rst_hl[%0d]: got %b want 0", i, highlight); end
        end
        rst = 1'b0;
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL rel0_hit: got %b want 0", hit); end
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL rel0_hl: got %b want 0", highlight); end
        step();
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL rel1_hit: got %b want 0", hit); end
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL rel1_hl: got %b want 0", highlight); end
    endtask

    task automatic test_snapshot_latency();
        do_reset();
        registers = '0; set_row(3, 16'hFFFF); cx = 11'd320; cy = 11'd240;
        render(11'd300, 11'd210);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL presnap_hit: got %b want 0", hit); end
        render(11'd0, 11'd0);
        pulse();
        x = 11'd300; y = 11'd210;
        step();
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL lat1_hit: got %b want 0", hit); end
        step();
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL lat2_hit: got %b want 1", hit); end
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL first_frame_hl: got %b want 0", highlight); end
        set_row(3, 16'h0000);
        step(); step(); step();
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL midframe_hit: got %b want 1", hit); end
        render(11'd303, 11'd210);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL gap_col: got %b want 0", hit); end
        render(11'd299, 11'd202);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL top_edge: got %b want 1", hit); end
        render(11'd299, 11'd201);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL above_top: got %b want 0", hit); end
        render(11'd299, 11'd217);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL bot_edge: got %b want 1", hit); end
        render(11'd299, 11'd218);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL below_bot: got %b want 0", hit); end
        render(11'd398, 11'd210);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL right_edge: got %b want 1", hit); end
        render(11'd400, 11'd210);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL past_right: got %b want 0", hit); end
    endtask

    task automatic test_highlight_lifetime();
        logic exp_hl [7];
        do_reset();
        registers = '0; cx = 11'd320; cy = 11'd240;
        pulse();
        set_row(5, 16'h1234);
        pulse();
        render(11'd243, 11'd270);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL row4_label_hit: got %b want 1", hit); end
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL row4_label_hl: got %b want 0", highlight); end
        render(11'd300, 11'd330);
        n_cmp++; if (highlight !== 1'b1) begin n_bad++; $display("FAIL hl_k: got %b want 1", highlight); end
        // Loads k+1..k+3 with no change: 2, 1, 0.
        exp_hl = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 3; f++) begin
            pulse(); render(11'd300, 11'd330);
            n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL hl_hit_k%0d: got %b want 1", f + 1, hit); end
            n_cmp++; if (highlight !== exp_hl[f]) begin n_bad++; $display("FAIL hl_k%0d: got %b want %b", f + 1, highlight, exp_hl[f]); end
        end
        // Change at m and again at m+1, then idle through m+4.
        set_row(5, 16'h1235); pulse();
        set_row(5, 16'h1236);
        for (int f = 3; f < 7; f++) begin
            pulse(); render(11'd300, 11'd330);
            n_cmp++; if (highlight !== exp_hl[f]) begin n_bad++; $display("FAIL reload_m%0d: got %b want %b", f - 2, highlight, exp_hl[f]); end
        end
        set_row(5, 16'h1237);
        frame_start = 1'b1; step(); step(); step(); frame_start = 1'b0;
        render(11'd300, 11'd330);
        n_cmp++; if (highlight !== 1'b1) begin n_bad++; $display("FAIL b2b_cnt1: got %b want 1", highlight); end
        pulse(); render(11'd300, 11'd330);
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL b2b_cnt0: got %b want 0", highlight); end
    endtask

    task automatic test_reset_with_frame();
        do_reset();
        registers = '0; set_row(3, 16'hFFFF); cx = 11'd320; cy = 11'd240;
        pulse();
        rst = 1'b1; frame_start = 1'b1; step();
        rst = 1'b0; frame_start = 1'b0;
        render(11'd300, 11'd210);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL rstfs_snap: got %b want 0", hit); end
        pulse(); render(11'd300, 11'd210);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL rstfs_load_hit: got %b want 1", hit); end
        n_cmp++; if (highlight !== 1'b0) begin n_bad++; $display("FAIL rstfs_valid: got %b want 0", highlight); end
    endtask

    task automatic test_params();
        do_reset();
        registers2 = '1; cx = 11'd1000; cy = 11'd1000;
        pulse2();
        render(11'd1023, 11'd775);
        n_cmp++; if (hit2 !== 1'b1) begin n_bad++; $display("FAIL p_row0: got %b want 1", hit2); end
        n_cmp++; if (highlight2 !== 1'b0) begin n_bad++; $display("FAIL p_row0_hl: got %b want 0", highlight2); end
        render(11'd1023, 11'd1225);
        n_cmp++; if (hit2 !== 1'b1) begin n_bad++; $display("FAIL p_row15: got %b want 1", hit2); end
        render(11'd1023, 11'd767);
        n_cmp++; if (hit2 !== 1'b1) begin n_bad++; $display("FAIL p_row0_top: got %b want 1", hit2); end
        render(11'd1023, 11'd766);
        n_cmp++; if (hit2 !== 1'b0) begin n_bad++; $display("FAIL p_above_row0: got %b want 0", hit2); end
        render(11'd1023, 11'd1232);
        n_cmp++; if (hit2 !== 1'b1) begin n_bad++; $display("FAIL p_row15_bot: got %b want 1", hit2); end
        render(11'd1023, 11'd1233);
        n_cmp++; if (hit2 !== 1'b0) begin n_bad++; $display("FAIL p_below_row15: got %b want 0", hit2); end
        render(11'd1023, 11'd790);
        n_cmp++; if (hit2 !== 1'b0) begin n_bad++; $display("FAIL p_between: got %b want 0", hit2); end
        // Row 0 of the small stack wraps to 10-210 mod 2048 = 1848.
        registers = '0; set_row(0, 16'hFFFF); cx = 11'd320; cy = 11'd10;
        pulse();
        render(11'd300, 11'd1848);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL wrap_row0: got %b want 1", hit); end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_start2 = 1'b0;
        x = '0; y = '0; cx = '0; cy = '0; registers = '0; registers2 = '0;
        test_reset();
        test_snapshot_latency();
        test_highlight_lifetime();
        test_reset_with_frame();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
